// File: rtl/mem_port_arbiter.sv
// Shares one cache/memory port between fetch (IF) and data (DM); optional fetch starvation guard under ARB_FETCH_GUARD_EN.
// Latency: grant in cycle 0, o_mem_req from cycle 1, owner o_X_valid the cycle after i_mem_valid.
// Backpressure: one transaction in flight; ready pulses only in IDLE; the issued request holds until i_mem_ready.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic [31:0] i_dm_addr,
    input  logic        i_dm_ren,
    input  logic        i_dm_wen,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_mask,
    output logic        o_dm_ready,
    output logic        o_dm_valid,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_dm;
    logic        kill;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ren_q;
    logic        wen_q;
    logic [3:0]  mask_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic        if_valid_q;
    logic        dm_valid_q;
    logic        grant_if;
    logic        grant_dm;
    logic        force_if;
    logic        rsp_fire;

`ifdef ARB_FETCH_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    // Counts DM wins while an unflushed fetch is waiting; saturates at LIMIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_if || (state == IDLE && !i_if_req)) begin
            starve_cnt <= 4'd0;
        end else if (grant_dm && i_if_req && !i_if_flush && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_if = (starve_cnt == LIMIT) && i_if_req && !i_if_flush;
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && !i_rst) begin
            if (i_dm_req && !force_if) begin
                grant_dm = 1'b1;
            end else if (i_if_req && !i_if_flush) begin
                grant_if = 1'b1;
            end
        end
    end

    assign rsp_fire = (state == WAIT) && i_mem_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_dm || grant_if) state_nxt = ISSUE;
            ISSUE:   if (i_mem_ready) state_nxt = WAIT;
            WAIT:    if (i_mem_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_if_ready  = grant_if;
        o_dm_ready  = grant_dm;
        o_mem_req   = (state == ISSUE);
        o_mem_addr  = addr_q;
        o_mem_ren   = ren_q;
        o_mem_wen   = wen_q;
        o_mem_wdata = wdata_q;
        o_mem_mask  = mask_q;
        o_if_valid  = if_valid_q;
        o_if_rdata  = if_rdata_q;
        o_dm_valid  = dm_valid_q;
        o_dm_rdata  = dm_rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner_dm   <= 1'b0;
            kill       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            mask_q     <= 4'h0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;

            if (grant_dm) begin
                owner_dm <= 1'b1;
                addr_q   <= i_dm_addr;
                ren_q    <= i_dm_ren;
                wen_q    <= i_dm_wen;
                wdata_q  <= i_dm_wdata;
                mask_q   <= i_dm_mask;
            end else if (grant_if) begin
                owner_dm <= 1'b0;
                addr_q   <= i_if_addr;
                ren_q    <= 1'b1;
                wen_q    <= 1'b0;
                wdata_q  <= 32'h0;
                mask_q   <= 4'hF;
            end

            // A redirect that lands while the fetch is still in flight lets the
            // downstream access finish but drops the response.
            if (state == IDLE) begin
                kill <= 1'b0;
            end else if (!owner_dm && i_if_flush) begin
                kill <= 1'b1;
            end

            if (rsp_fire) begin
                if (owner_dm) begin
                    dm_rdata_q <= i_mem_rdata;
                    dm_valid_q <= 1'b1;
                end else if (!kill && !i_if_flush) begin
                    if_rdata_q <= i_mem_rdata;
                    if_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a configurable downstream responder.
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_flush;
    logic        o_if_ready;
    logic        o_if_valid;
    logic [31:0] o_if_rdata;
    logic        i_dm_req;
    logic [31:0] i_dm_addr;
    logic        i_dm_ren;
    logic        i_dm_wen;
    logic [31:0] i_dm_wdata;
    logic [3:0]  i_dm_mask;
    logic        o_dm_ready;
    logic        o_dm_valid;
    logic [31:0] o_dm_rdata;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_ready(o_if_ready), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req), .i_dm_addr(i_dm_addr), .i_dm_ren(i_dm_ren),
        .i_dm_wen(i_dm_wen), .i_dm_wdata(i_dm_wdata), .i_dm_mask(i_dm_mask),
        .o_dm_ready(o_dm_ready), .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        bit          is_dm;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    int          stall_cfg = 0;
    int          wait_cfg  = 0;
    int          stall_cnt = 0;
    int          resp_cnt  = 0;
    bit          resp_due  = 0;
    bit          ovr_vld   = 0;
    logic [31:0] ovr_dat   = 32'h0;
    logic [31:0] resp_dat  = 32'h0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic push_exp(input bit d, input bit c, input logic [31:0] v);
        exp_t e;
        e.is_dm = d;
        e.chk   = c;
        e.dat   = v;
        sb.push_back(e);
    endtask

    // Downstream model: optional accept stall, optional response delay.
    always @(negedge i_clk) begin
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        if (resp_due) begin
            if (resp_cnt == 0) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = resp_dat;
                resp_due    = 1'b0;
            end else begin
                resp_cnt--;
            end
        end else if (o_mem_req === 1'b1) begin
            if (stall_cnt < stall_cfg) begin
                stall_cnt++;
            end else begin
                i_mem_ready = 1'b1;
                stall_cnt   = 0;
                resp_due    = 1'b1;
                resp_cnt    = wait_cfg;
                resp_dat    = ovr_vld ? ovr_dat : mem_fn(o_mem_addr);
                ovr_vld     = 1'b0;
            end
        end
    end

    // Response monitor: every valid pulse pops the scoreboard.
    always @(negedge i_clk) begin
        exp_t e;
        #1;
        if (o_if_valid === 1'b1 || o_dm_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: if_valid=%b dm_valid=%b, expected no response", o_if_valid, o_dm_valid);
            end else begin
                e = sb.pop_front();
                if (o_dm_valid !== e.is_dm || o_if_valid !== !e.is_dm) begin
                    errors++;
                    $display("FAIL resp_owner: if_valid=%b dm_valid=%b, expected dm=%b", o_if_valid, o_dm_valid, e.is_dm);
                end else if (e.chk && (e.is_dm ? o_dm_rdata : o_if_rdata) !== e.dat) begin
                    errors++;
                    $display("FAIL resp_data: got %h expected %h", e.is_dm ? o_dm_rdata : o_if_rdata, e.dat);
                end
            end
        end
        if (o_if_ready === 1'b1 || o_dm_ready === 1'b1) begin
            checks++;
            if (o_if_ready === 1'b1 && o_dm_ready === 1'b1) begin
                errors++;
                $display("FAIL both_ready: if_ready=1 dm_ready=1, expected at most one");
            end
        end
    end

    task automatic wait_ready(output bit got_if, output bit got_dm);
        got_if = 0;
        got_dm = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (o_if_ready === 1'b1 || o_dm_ready === 1'b1) begin
                got_if = o_if_ready;
                got_dm = o_dm_ready;
                return;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge i_clk);
            #2;
            if (sb.size() == 0) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_if_req = 1'b1;
        i_dm_req = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        checks++;
        if ({o_if_ready, o_dm_ready, o_if_valid, o_dm_valid, o_mem_req, o_mem_ren, o_mem_wen,
             o_mem_mask, o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b%b req=%b addr=%h, expected all zero",
                     o_if_ready, o_dm_ready, o_mem_req, o_mem_addr);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_if_req = 1'b0;
        i_dm_req = 1'b0;
        #1;
        checks++;
        if (o_mem_req !== 1'b0 || o_if_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req=%b if_ready=%b, expected 0 0", o_mem_req, o_if_ready);
        end
    endtask

    task automatic test_if_only;
        bit ok;
        @(negedge i_clk);
        ovr_vld = 1'b1;
        ovr_dat = 32'h0000_0013;
        i_if_req = 1'b1;
        i_if_addr = 32'h100;
        push_exp(1'b0, 1'b1, 32'h0000_0013);
        #1;
        checks++;
        if (o_if_ready !== 1'b1 || o_dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL if_only_grant: if_ready=%b dm_ready=%b, expected 1 0", o_if_ready, o_dm_ready);
        end
        @(negedge i_clk);
        i_if_req = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_mask} !== {1'b1, 32'h100, 1'b1, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL if_only_issue: req=%b addr=%h ren=%b wen=%b mask=%h, expected 1 100 1 0 f",
                     o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_mask);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL if_only_wait_req: req=%b, expected 0", o_mem_req);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if ({o_if_valid, o_if_rdata} !== {1'b1, 32'h0000_0013}) begin
            errors++;
            $display("FAIL if_only_resp: valid=%b rdata=%h, expected 1 00000013", o_if_valid, o_if_rdata);
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (o_if_valid !== 1'b0) begin
            errors++;
            $display("FAIL if_valid_pulse: valid=%b, expected 0", o_if_valid);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL if_only_drain: pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        bit seen;
        @(negedge i_clk);
        i_dm_req = 1'b1;
        i_dm_addr = 32'h200;
        i_dm_ren = 1'b0;
        i_dm_wen = 1'b1;
        i_dm_wdata = 32'hDEADBEEF;
        i_dm_mask = 4'h3;
        i_if_req = 1'b1;
        i_if_addr = 32'h104;
        push_exp(1'b1, 1'b0, 32'h0);
        push_exp(1'b0, 1'b1, mem_fn(32'h104));
        #1;
        checks++;
        if ({o_dm_ready, o_if_ready} !== 2'b10) begin
            errors++;
            $display("FAIL simul_dm_first: dm_ready=%b if_ready=%b, expected 1 0", o_dm_ready, o_if_ready);
        end
        @(negedge i_clk);
        i_dm_req = 1'b0;
        i_dm_wen = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask} !==
            {1'b1, 32'h200, 1'b0, 1'b1, 32'hDEADBEEF, 4'h3}) begin
            errors++;
            $display("FAIL simul_store_fields: req=%b addr=%h ren=%b wen=%b wdata=%h mask=%h, expected 1 200 0 1 deadbeef 3",
                     o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            #1;
            if (o_dm_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || o_if_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_if_after_dm: dm_valid_seen=%b if_ready=%b, expected 1 1", seen, o_if_ready);
        end
        @(negedge i_clk);
        i_if_req = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL simul_drain: pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_stall;
        bit ok;
        bit gi;
        bit gd;
        int n;
        bit stable;
        bit extra;
        stall_cfg = 5;
        @(negedge i_clk);
        i_if_req = 1'b1;
        i_if_addr = 32'h300;
        push_exp(1'b0, 1'b1, mem_fn(32'h300));
        push_exp(1'b1, 1'b1, mem_fn(32'h400));
        #1;
        checks++;
        if (o_if_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_grant: if_ready=%b, expected 1", o_if_ready);
        end
        @(negedge i_clk);
        i_if_req = 1'b0;
        i_dm_req = 1'b1;
        i_dm_addr = 32'h400;
        i_dm_ren = 1'b1;
        i_dm_wen = 1'b0;
        i_dm_wdata = 32'h0;
        i_dm_mask = 4'hF;
        n = 0;
        stable = 1;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (o_mem_req === 1'b1) begin
                n++;
                if ({o_mem_addr, o_mem_ren, o_mem_wen, o_mem_mask} !== {32'h300, 1'b1, 1'b0, 4'hF}) stable = 0;
            end
            if (o_if_ready === 1'b1 || o_dm_ready === 1'b1) extra = 1;
            if (o_mem_req !== 1'b1 && n > 0) break;
            @(negedge i_clk);
        end
        stall_cfg = 0;
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL stall_req_cycles: got %0d, expected 6", n);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL stall_fields_stable: stable=0, expected 1");
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL stall_no_grant: grant seen=1, expected 0");
        end
        @(negedge i_clk);
        wait_ready(gi, gd);
        checks++;
        if (gd !== 1'b1) begin
            errors++;
            $display("FAIL stall_dm_after: dm_ready=%b, expected 1", gd);
        end
        @(negedge i_clk);
        i_dm_req = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_drain: pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_flush;
        bit ok;
        bit saw;
        wait_cfg = 2;
        ovr_vld = 1'b1;
        ovr_dat = 32'hAAAA5555;
        @(negedge i_clk);
        i_if_req = 1'b1;
        i_if_addr = 32'h500;
        #1;
        checks++;
        if (o_if_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_grant: if_ready=%b, expected 1", o_if_ready);
        end
        @(negedge i_clk);
        i_if_req = 1'b0;
        @(negedge i_clk);
        i_if_flush = 1'b1;
        @(negedge i_clk);
        i_if_flush = 1'b0;
        saw = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (o_if_valid === 1'b1) saw = 1;
            @(negedge i_clk);
        end
        wait_cfg = 0;
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL flush_suppress: if_valid seen=1, expected 0");
        end
        i_if_req = 1'b1;
        i_if_addr = 32'h600;
        push_exp(1'b0, 1'b1, mem_fn(32'h600));
        #1;
        checks++;
        if (o_if_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_next_grant: if_ready=%b, expected 1", o_if_ready);
        end
        @(negedge i_clk);
        i_if_req = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flush_drain: pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        bit bad;
        wait_cfg = 3;
        @(negedge i_clk);
        i_if_req = 1'b1;
        i_if_addr = 32'h700;
        @(negedge i_clk);
        i_if_req = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++;
        if ({o_if_ready, o_dm_ready, o_if_valid, o_dm_valid, o_mem_req, o_mem_ren, o_mem_wen,
             o_mem_mask, o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: req=%b addr=%h ren=%b rdata=%h, expected all zero",
                     o_mem_req, o_mem_addr, o_mem_ren, o_if_rdata);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            #1;
            if (o_if_valid !== 1'b0 || o_mem_req !== 1'b0 || o_if_rdata !== 32'h0) bad = 1;
        end
        wait_cfg = 0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_ignore_valid: activity=1, expected 0");
        end
    endtask

    task automatic test_starve;
        bit ok;
        bit gi;
        bit gd;
        bit exp_dm[6];
`ifdef ARB_FETCH_GUARD_EN
        exp_dm = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            push_exp(exp_dm[i], 1'b1, mem_fn(exp_dm[i] ? 32'h900 : 32'h800));
        end
        @(negedge i_clk);
        i_if_req = 1'b1;
        i_if_addr = 32'h800;
        i_dm_req = 1'b1;
        i_dm_addr = 32'h900;
        i_dm_ren = 1'b1;
        i_dm_wen = 1'b0;
        i_dm_mask = 4'hF;
        for (int i = 0; i < 6; i++) begin
            wait_ready(gi, gd);
            checks++;
            if (gd !== exp_dm[i] || gi === gd) begin
                errors++;
                $display("FAIL grant_order[%0d]: if=%b dm=%b, expected dm=%b", i, gi, gd, exp_dm[i]);
            end
            @(negedge i_clk);
        end
        i_if_req = 1'b0;
        i_dm_req = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL starve_drain: pending=%0d, expected 0", sb.size());
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_if_req = 1'b0;
        i_if_addr = 32'h0;
        i_if_flush = 1'b0;
        i_dm_req = 1'b0;
        i_dm_addr = 32'h0;
        i_dm_ren = 1'b0;
        i_dm_wen = 1'b0;
        i_dm_wdata = 32'h0;
        i_dm_mask = 4'h0;
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_rdata = 32'h0;
        test_reset();
        test_if_only();
        test_simultaneous();
        test_stall();
        test_flush();
        test_reset_mid();
        test_starve();
        repeat (3) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
